// File: rtl/lvt_write_issuer_pkg.sv
// Shared definitions for the LVT write issuer: lane count, data width and the
// buffered request record.
package lvt_write_issuer_pkg;

    localparam int LANES      = 4;
    localparam int DATA_W     = 32;
    localparam int MAX_ADDR_W = 32;

    function automatic int addr_w(input int blocksize);
        return blocksize + 1;
    endfunction

    // Addresses are held zero-extended so one record type serves every BLOCKSIZE.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } req_t;

endpackage

// File: rtl/lvt_issue_pack.sv
// Picks the longest in-order prefix of up to four head entries whose addresses
// are pairwise distinct, so no two same-address writes share a cycle.
module lvt_issue_pack
    import lvt_write_issuer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [LANES-1:0][MAX_ADDR_W-1:0] head_addr,
    input  logic [CNT_W-1:0]                 count,
    input  logic                             hold,
    output logic [LANES-1:0]                 issue,
    output logic [2:0]                       issue_cnt
);

    logic [LANES-1:1] dup;
    logic             run;

    always_comb begin
        dup = '0;
        for (int j = 1; j < LANES; j++) begin
            for (int k = 0; k < j; k++) begin
                if (head_addr[j] == head_addr[k]) begin
                    dup[j] = 1'b1;
                end
            end
        end
    end

    // A lane issues only while every earlier lane issued, so one blocked entry ends the prefix.
    always_comb begin
        issue     = '0;
        issue_cnt = '0;
        run       = (count != '0) && !hold;
        issue[0]  = run;
        for (int j = 1; j < LANES; j++) begin
            run      = run && (count > CNT_W'(j)) && !dup[j];
            issue[j] = run;
        end
        for (int j = 0; j < LANES; j++) begin
            issue_cnt = issue_cnt + 3'(issue[j]);
        end
    end

endmodule

// File: rtl/lvt_write_issuer.sv
// Buffers an ordered write stream in a circular FIFO and drains it onto the
// four LVT RAM write ports, several writes per cycle when addresses allow.
module lvt_write_issuer
    import lvt_write_issuer_pkg::*;
#(
    parameter int BLOCKSIZE = 10,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BLOCKSIZE:0]       in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic [BLOCKSIZE:0]       w_addr_1,
    output logic [BLOCKSIZE:0]       w_addr_2,
    output logic [BLOCKSIZE:0]       w_addr_3,
    output logic [BLOCKSIZE:0]       w_addr_4,
    output logic [DATA_W-1:0]        w_din_1,
    output logic [DATA_W-1:0]        w_din_2,
    output logic [DATA_W-1:0]        w_din_3,
    output logic [DATA_W-1:0]        w_din_4,
    output logic                     w_enb_1,
    output logic                     w_enb_2,
    output logic                     w_enb_3,
    output logic                     w_enb_4,
    output logic [2:0]               issue_cnt,
    output logic                     idle
);

    localparam int AW    = addr_w(BLOCKSIZE);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    req_t                            mem [DEPTH];
    logic [PW-1:0]                   rd_ptr;
    logic [PW-1:0]                   wr_ptr;
    logic [CNT_W-1:0]                count;
    logic                            accept;
    req_t [LANES-1:0]                head;
    logic [LANES-1:0][MAX_ADDR_W-1:0] head_addr;
    logic [LANES-1:0]                issue;

    assign in_ready = (count != CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign idle     = (count == '0);

    // Head window wraps through the pointer width, so wrapping prefixes need no special case.
    always_comb begin
        head      = '0;
        head_addr = '0;
        for (int j = 0; j < LANES; j++) begin
            head[j]      = mem[rd_ptr + PW'(j)];
            head_addr[j] = head[j].addr;
        end
    end

    lvt_issue_pack #(
        .CNT_W(CNT_W)
    ) u_pack (
        .head_addr(head_addr),
        .count    (count),
        .hold     (hold),
        .issue    (issue),
        .issue_cnt(issue_cnt)
    );

    // Storage is never cleared; reset only rewinds pointers and count.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{addr: MAX_ADDR_W'(in_addr), data: in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + PW'(issue_cnt);
            count  <= count + CNT_W'(accept) - CNT_W'(issue_cnt);
        end
    end

    assign w_addr_1 = head[0].addr[AW-1:0];
    assign w_addr_2 = head[1].addr[AW-1:0];
    assign w_addr_3 = head[2].addr[AW-1:0];
    assign w_addr_4 = head[3].addr[AW-1:0];
    assign w_din_1  = head[0].data;
    assign w_din_2  = head[1].data;
    assign w_din_3  = head[2].data;
    assign w_din_4  = head[3].data;
    assign w_enb_1  = issue[0];
    assign w_enb_2  = issue[1];
    assign w_enb_3  = issue[2];
    assign w_enb_4  = issue[3];

endmodule

// File: tb/tb_lvt_write_issuer.sv
// Directed bench for lvt_write_issuer with hand-computed expectations and a
// small RAM model fed from the write ports.
module tb_lvt_write_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_addr;
    logic [31:0] in_data;
    logic        hold;
    logic [10:0] w_addr_1, w_addr_2, w_addr_3, w_addr_4;
    logic [31:0] w_din_1, w_din_2, w_din_3, w_din_4;
    logic        w_enb_1, w_enb_2, w_enb_3, w_enb_4;
    logic [2:0]  issue_cnt;
    logic        idle;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] ram_model [0:2047];

    lvt_write_issuer #(
        .BLOCKSIZE(10),
        .DEPTH    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .w_addr_1 (w_addr_1),
        .w_addr_2 (w_addr_2),
        .w_addr_3 (w_addr_3),
        .w_addr_4 (w_addr_4),
        .w_din_1  (w_din_1),
        .w_din_2  (w_din_2),
        .w_din_3  (w_din_3),
        .w_din_4  (w_din_4),
        .w_enb_1  (w_enb_1),
        .w_enb_2  (w_enb_2),
        .w_enb_3  (w_enb_3),
        .w_enb_4  (w_enb_4),
        .issue_cnt(issue_cnt),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // Lanes applied in port order, mirroring how the RAM would commit them.
    always @(posedge clk) begin
        if (w_enb_1) ram_model[w_addr_1] <= w_din_1;
        if (w_enb_2) ram_model[w_addr_2] <= w_din_2;
        if (w_enb_3) ram_model[w_addr_3] <= w_din_3;
        if (w_enb_4) ram_model[w_addr_4] <= w_din_4;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [10:0] a, input logic [31:0] d, input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enbs();
        return {w_enb_4, w_enb_3, w_enb_2, w_enb_1};
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_idle", 64'(idle), 64'd1);
        checkOutput("reset_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_cnt", 64'(issue_cnt), 64'd0);
        checkOutput("reset_enb", 64'(enbs()), 64'h0);

        // Single write
        applyStimulus(1'b1, 11'h005, 32'hDEADBEEF, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("single_enb", 64'(enbs()), 64'b0001);
        checkOutput("single_addr", 64'(w_addr_1), 64'h005);
        checkOutput("single_din", 64'(w_din_1), 64'hDEADBEEF);
        checkOutput("single_cnt", 64'(issue_cnt), 64'd1);
        tick();
        checkOutput("single_idle", 64'(idle), 64'd1);

        // Batch packing
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 11'(11'h010 + i), 32'h1000 + 32'(i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        #1;
        checkOutput("hold_cnt", 64'(issue_cnt), 64'd0);
        checkOutput("hold_enb", 64'(enbs()), 64'h0);
        hold = 1'b0;
        #1;
        checkOutput("batch_cnt", 64'(issue_cnt), 64'd4);
        checkOutput("batch_enb", 64'(enbs()), 64'b1111);
        checkOutput("batch_addrs", 64'({w_addr_4, w_addr_3, w_addr_2, w_addr_1}), 64'({11'h013, 11'h012, 11'h011, 11'h010}));
        checkOutput("batch_din4", 64'(w_din_4), 64'h1003);
        tick();
        checkOutput("batch2_cnt", 64'(issue_cnt), 64'd1);
        checkOutput("batch2_addr", 64'(w_addr_1), 64'h014);
        checkOutput("batch2_din", 64'(w_din_1), 64'h1004);
        checkOutput("batch2_enb", 64'(enbs()), 64'b0001);
        tick();
        checkOutput("batch_idle", 64'(idle), 64'd1);

        // Conflict split
        applyStimulus(1'b1, 11'h020, 32'hA0, 1'b1); tick();
        applyStimulus(1'b1, 11'h021, 32'hA1, 1'b1); tick();
        applyStimulus(1'b1, 11'h020, 32'hA2, 1'b1); tick();
        applyStimulus(1'b1, 11'h022, 32'hA3, 1'b1); tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("conf1_cnt", 64'(issue_cnt), 64'd2);
        checkOutput("conf1_enb", 64'(enbs()), 64'b0011);
        checkOutput("conf1_addrs", 64'({w_addr_2, w_addr_1}), 64'({11'h021, 11'h020}));
        checkOutput("conf1_din", 64'({w_din_2, w_din_1}), {32'hA1, 32'hA0});
        tick();
        checkOutput("conf2_cnt", 64'(issue_cnt), 64'd2);
        checkOutput("conf2_addrs", 64'({w_addr_2, w_addr_1}), 64'({11'h022, 11'h020}));
        checkOutput("conf2_din", 64'({w_din_2, w_din_1}), {32'hA3, 32'hA2});
        tick();
        checkOutput("conf_idle", 64'(idle), 64'd1);
        checkOutput("conf_ram20", 64'(ram_model[11'h020]), 64'hA2);
        checkOutput("conf_ram21", 64'(ram_model[11'h021]), 64'hA1);

        // Full and wrap
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 11'(11'h030 + i), 32'hC0 + 32'(i), 1'b1);
            tick();
        end
        applyStimulus(1'b1, 11'h03F, 32'hFF, 1'b1);
        #1;
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        checkOutput("full_idle", 64'(idle), 64'd0);
        tick();
        hold = 1'b0;
        #1;
        checkOutput("full_rel_cnt", 64'(issue_cnt), 64'd4);
        checkOutput("full_rel_ready", 64'(in_ready), 64'd0);
        checkOutput("full_rel_addrs", 64'({w_addr_4, w_addr_3, w_addr_2, w_addr_1}), 64'({11'h033, 11'h032, 11'h031, 11'h030}));
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 11'(11'h040 + i), 32'hD0 + 32'(i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("wrap_cnt", 64'(issue_cnt), 64'd4);
        checkOutput("wrap_addrs", 64'({w_addr_4, w_addr_3, w_addr_2, w_addr_1}), 64'({11'h037, 11'h036, 11'h035, 11'h034}));
        checkOutput("wrap_din_lo", 64'({w_din_2, w_din_1}), {32'hC5, 32'hC4});
        checkOutput("wrap_din_hi", 64'({w_din_4, w_din_3}), {32'hC7, 32'hC6});
        tick();
        checkOutput("wrap2_cnt", 64'(issue_cnt), 64'd3);
        checkOutput("wrap2_enb", 64'(enbs()), 64'b0111);
        checkOutput("wrap2_addrs", 64'({w_addr_3, w_addr_2, w_addr_1}), 64'({11'h042, 11'h041, 11'h040}));
        checkOutput("wrap2_din", 64'({w_din_3, w_din_1}), {32'hD2, 32'hD0});
        tick();
        checkOutput("wrap_idle", 64'(idle), 64'd1);

        // Reset mid-operation, with a request presented during reset
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 11'(11'h050 + i), 32'h500 + 32'(i), 1'b1);
            tick();
        end
        checkOutput("pre_rst_idle", 64'(idle), 64'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 11'h077, 32'h777, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("midrst_idle", 64'(idle), 64'd1);
        checkOutput("midrst_enb", 64'(enbs()), 64'h0);
        checkOutput("midrst_cnt", 64'(issue_cnt), 64'd0);
        checkOutput("midrst_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 11'h060, 32'h600, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("post_rst_enb", 64'(enbs()), 64'b0001);
        checkOutput("post_rst_addr", 64'(w_addr_1), 64'h060);
        checkOutput("post_rst_din", 64'(w_din_1), 64'h600);
        tick();
        checkOutput("post_rst_idle", 64'(idle), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lvt_write_issuer.md
# lvt_write_issuer

Write-side initiator for the 4-read/4-write live-value-table RAM. Accepts one ordered stream of single-word write requests through a valid/ready handshake and buffers them in a FIFO. Each cycle it issues the longest in-order prefix of up to four buffered writes with pairwise-distinct addresses onto the RAM's four write ports. This keeps program order intact and never presents two same-address writes in one cycle, so the last-writer choice in the LVT never decides the result.

## Interface
Parameters:
- BLOCKSIZE, 10, RAM address MSB index; address width is BLOCKSIZE+1.
- DEPTH, 8, FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request buffer can accept.
- in_addr  in  BLOCKSIZE+1  write address.
- in_data  in  32  write data.
- hold  in  1  suppresses issue this cycle; accepts still allowed.
- w_addr_1..w_addr_4  out  BLOCKSIZE+1 each  RAM write addresses.
- w_din_1..w_din_4  out  32 each  RAM write data.
- w_enb_1..w_enb_4  out  1 each  RAM write enables.
- issue_cnt  out  3  number of writes issued this cycle, 0..4.
- idle  out  1  FIFO empty.

## Operation
- Storage is a circular FIFO with rd_ptr, wr_ptr and count, where count is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Accept: in_ready = (count != DEPTH). There is no bypass, so a pop does not raise in_ready in the same cycle. A handshake occurs when in_valid and in_ready are both high; the entry is written at wr_ptr and wr_ptr advances by 1.
- Pack rule, with entries e0..e3 taken at rd_ptr+0..3 (mod DEPTH):
  - e0 issues if count ≥ 1 and hold = 0.
  - ej (j = 1..3) issues if ej-1 issued, count > j, and addr(ej) differs from addr(e0..ej-1).
  - issue_cnt is the number of issued entries.
- Port mapping: issued ej drives w_addr_(j+1), w_din_(j+1) and w_enb_(j+1) = 1. Ports for non-issued lanes drive enb = 0, and their addr/data are don't-care but must be driven; drive them from ej.
- Pop: rd_ptr advances by issue_cnt.
- Count update: count_next = count + accept − issue_cnt. Accept and pop in the same cycle are legal.
- The write outputs are combinational from registered FIFO state and hold only. There is no path from in_* to w_*.
- idle = (count == 0).

## Timing
- Reset (rst high at a rising edge):
  - rd_ptr, wr_ptr and count go to 0, so idle = 1, in_ready = 1, issue_cnt = 0 and every w_enb_k = 0.
  - FIFO contents are not cleared.
  - Reset mid-operation discards all buffered writes; no partial issue occurs in the cycle after reset.
  - An accept presented in the same cycle as rst is dropped.
- Latency: a request accepted at edge N can appear on a write port during cycle N+1, and is consumed at edge N+1.
- Throughput: 4 writes per cycle when addresses are distinct and the FIFO holds at least 4 entries. Input is limited to 1 accept per cycle, so the steady state is 1 write per cycle.
- Full: with count = DEPTH, in_ready = 0 for that whole cycle, even if issue_cnt > 0.
- Wrap-around: a prefix that crosses index DEPTH−1 to 0 packs identically to a non-wrapping one.
- hold = 1: issue_cnt = 0 and all w_enb = 0; accepts continue until full.
- Duplicate address: packing stops at the first entry whose address repeats an earlier address in the prefix. That entry issues next cycle in lane 1.

## Structure
- Shared package holds:
  - LANES = 4.
  - DATA_W = 32.
  - An address-width function of BLOCKSIZE.
  - The request struct {addr, data}.
- One sub-module, lvt_issue_pack: combinational prefix/conflict logic. It takes the 4 head entries, count and hold, and produces per-lane issue bits and issue_cnt. The FIFO and pointers live in the top.

## Test plan
- Reset then idle: rst for 2 cycles → idle = 1, in_ready = 1, all w_enb = 0, issue_cnt = 0.
- Single write: accept addr 0x005, data 0xDEADBEEF at edge N → cycle N+1 shows w_enb_1 = 1, w_addr_1 = 0x005, w_din_1 = 0xDEADBEEF, issue_cnt = 1; cycle N+2 shows idle = 1.
- Batch packing: set hold = 1, push addresses 0x010, 0x011, 0x012, 0x013, 0x014, then release hold.
  - First cycle: ports 1–4 carry 0x010–0x013, issue_cnt = 4.
  - Next cycle: port 1 carries 0x014, issue_cnt = 1.
- Conflict split: with hold, push addresses 0x020, 0x021, 0x020, 0x022, then release hold.
  - First cycle: issue_cnt = 2, carrying 0x020 and 0x021.
  - Next cycle: port 1 = 0x020 with the third data word, port 2 = 0x022; issue_cnt = 2.
  - A RAM read of 0x020 afterwards returns the third data word.
- Full and wrap: with hold, push 8 requests → in_ready = 0 and the 9th in_valid is not accepted. Then:
  - Release hold for one cycle → issue_cnt = 4 and in_ready stays 0 in that cycle.
  - Push 3 more, then release hold → a prefix that wraps index 7→0 packs correctly, and data order is preserved.
- Reset mid-operation: assert rst with 6 buffered entries → the next cycle shows idle = 1 and no w_enb. New traffic issues normally afterwards.
